apb_master_bridge: RTL and testbench

Single-outstanding APB requester that turns a simple valid/ready command stream into APB SETUP/ACCESS transfers. It captures the completion (read data, slave error) into a held response register. It is the initiator end of the APB link and drives the existing APB memory slave (128x32) directly, so the bench and system logic can reach that memory without hand-sequencing PSEL/PENABLE.

---
 rtl/apb_master_bridge.sv | 173 +++++++++++++++++
 tb/tb_apb_master_bridge.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding APB requester. It turns a valid/ready command
//   stream into APB SETUP/ACCESS transfers and holds each completion in a response register.
// Latency: accept at edge N -> SETUP in cycle N+1, ACCESS from N+2, response valid
//   the cycle after PREADY is sampled. This is N+3 with zero wait states.
// Backpressure: o_cmd_ready only in IDLE, and only when the held response is empty
//   or is being consumed in the same cycle. A blocked response stalls the APB bus.
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES
//   consecutive PREADY=0 cycles. The abort returns an error response and pulses o_timeout.
// Ports:
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_cmd_* / o_cmd_ready   : command stream (write, addr, wdata)
//   o_rsp_* / i_rsp_ready   : held response (rdata, err)
//   o_P* / i_P*             : APB requester signals
//   o_timeout               : one-cycle pulse on timeout abort
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 7,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_write,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic [ADDR_WIDTH-1:0] o_PADDR,
  output logic                  o_PWRITE,
  output logic                  o_PSEL,
  output logic                  o_PENABLE,
  output logic [DATA_WIDTH-1:0] o_PWDATA,
  input  logic                  i_PREADY,
  input  logic [DATA_WIDTH-1:0] i_PRDATA,
  input  logic                  i_PSLVERR,
  output logic                  o_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_accept;
  logic                  w_done;
  logic                  w_abort;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic                  r_pwrite;
  logic [DATA_WIDTH-1:0] r_pwdata;

  assign w_accept = i_cmd_valid && o_cmd_ready;
  assign w_done   = (r_state == ST_ACCESS) && i_PREADY;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = ST_SETUP;
      ST_SETUP:  w_state_nxt = ST_ACCESS;
      // A PREADY completion and a timeout abort both end the transfer.
      ST_ACCESS: if (i_PREADY || w_abort) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    o_cmd_ready = 1'b0;
    o_PSEL      = 1'b0;
    o_PENABLE   = 1'b0;
    case (r_state)
      // A response consumed this cycle frees the register for the next command.
      ST_IDLE:   o_cmd_ready = !r_rsp_valid || i_rsp_ready;
      ST_SETUP:  o_PSEL = 1'b1;
      ST_ACCESS: begin
        o_PSEL    = 1'b1;
        o_PENABLE = 1'b1;
      end
      default: begin
        o_cmd_ready = 1'b0;
      end
    endcase
  end

  // Address, direction and write data change only on accept. They then hold through
  // the transfer and while idle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
    end else if (w_accept) begin
      r_paddr  <= i_cmd_addr;
      r_pwrite <= i_cmd_write;
      r_pwdata <= i_cmd_wdata;
    end
  end

  // Response register. A reload from a completion takes priority over a consume.
  // In practice the two never coincide, because completion happens only in ACCESS.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_done || w_abort) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err   <= w_done ? i_PSLVERR : 1'b1;
      r_rsp_rdata <= (w_done && !r_pwrite) ? i_PRDATA : '0;
    end else if (r_rsp_valid && i_rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_to_cnt;
  logic             r_timeout;

  // Abort on the TIMEOUT_CYCLES-th consecutive not-ready ACCESS cycle.
  // A PREADY=1 in that cycle is a normal completion instead.
  assign w_abort = (r_state == ST_ACCESS) && !i_PREADY &&
                   (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_abort;
      if (w_accept) begin
        r_to_cnt <= '0;
      end else if ((r_state == ST_ACCESS) && !i_PREADY) begin
        r_to_cnt <= r_to_cnt + CNT_W'(1);
      end
    end
  end

  assign o_timeout = r_timeout;
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign w_abort   = 1'b0;
  assign o_timeout = 1'b0;
`endif

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;
  assign o_PADDR     = r_paddr;
  assign o_PWRITE    = r_pwrite;
  assign o_PWDATA    = r_pwdata;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed checks of the APB requester bridge.
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_apb_master_bridge;
  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [6:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [6:0]  paddr;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        timeout;

  int total = 0;
  int bad   = 0;

  apb_master_bridge #(.ADDR_WIDTH(7), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
    .o_rsp_err(rsp_err),
    .o_PADDR(paddr), .o_PWRITE(pwrite), .o_PSEL(psel), .o_PENABLE(penable),
    .o_PWDATA(pwdata), .i_PREADY(pready), .i_PRDATA(prdata), .i_PSLVERR(pslverr),
    .o_timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command from the current falling edge and act as the APB slave.
  // The slave answers PREADY on ACCESS cycle number waits+1.
  // The task returns at the falling edge where the response is first seen, or after 200 cycles.
  task automatic run_xfer(input logic wr, input logic [6:0] addr, input logic [31:0] wd,
                          input int waits, input logic [31:0] prd, input logic serr,
                          output int lat, output int acc, output int psel_n,
                          output bit stable, output bit acc_ok);
    acc_ok = cmd_ready;
    stable = 1'b1;
    lat = 0; acc = 0; psel_n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    pready = 1'b0; pslverr = 1'b0; prdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      lat++;
      if (rsp_valid) break;
      if (psel) begin
        psel_n++;
        if (paddr !== addr || pwrite !== wr || pwdata !== wd) stable = 1'b0;
      end
      if (psel && penable) begin
        acc++;
        pready  = (acc > waits);
        prdata  = pready ? prd : 32'hBAD0_BAD0;
        pslverr = pready ? serr : 1'b0;
      end else begin
        pready = 1'b0;
      end
    end
    pready = 1'b0; pslverr = 1'b0;
  endtask

  int lat, acc, psel_n;
  bit stable, acc_ok, hold_ok;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_timeout", timeout, 0);
    rst = 1'b0;
    @(negedge clk);

    // Write 0xDEADBEEF to 0x05 with zero wait states. PRDATA must not leak into the write response.
    run_xfer(1'b1, 7'h05, 32'hDEAD_BEEF, 0, 32'h1234_5678, 1'b0, lat, acc, psel_n, stable, acc_ok);
    chk("wr_accept", acc_ok, 1);
    chk("wr_latency", lat, 3);
    chk("wr_psel_cycles", psel_n, 2);
    chk("wr_penable_cycles", acc, 1);
    chk("wr_addr_data_stable", stable, 1);
    chk("wr_psel_at_rsp", psel, 0);
    chk("wr_rsp_err", rsp_err, 0);
    chk("wr_rsp_rdata", rsp_rdata, 0);
    chk("wr_paddr_hold", paddr, 7'h05);
    @(negedge clk);
    chk("wr_rsp_consumed", rsp_valid, 0);

    // Read 0x05 with two wait states.
    run_xfer(1'b0, 7'h05, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, lat, acc, psel_n, stable, acc_ok);
    chk("rd_accept", acc_ok, 1);
    chk("rd_latency", lat, 5);
    chk("rd_access_cycles", acc, 3);
    chk("rd_addr_stable", stable, 1);
    chk("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("rd_rsp_err", rsp_err, 0);
    @(negedge clk);

    // Slave error on read of 0x7F, then a normal read.
    run_xfer(1'b0, 7'h7F, 32'h0, 0, 32'hA5A5_0001, 1'b1, lat, acc, psel_n, stable, acc_ok);
    chk("err_latency", lat, 3);
    chk("err_rsp_err", rsp_err, 1);
    chk("err_rsp_rdata", rsp_rdata, 32'hA5A5_0001);
    @(negedge clk);
    run_xfer(1'b0, 7'h10, 32'h0, 1, 32'h0000_CAFE, 1'b0, lat, acc, psel_n, stable, acc_ok);
    chk("after_err_accept", acc_ok, 1);
    chk("after_err_latency", lat, 4);
    chk("after_err_rsp_err", rsp_err, 0);
    chk("after_err_rsp_rdata", rsp_rdata, 32'h0000_CAFE);
    @(negedge clk);

    // Blocked response: hold rsp_ready low for 10 cycles with a command pending.
    rsp_ready = 1'b0;
    run_xfer(1'b1, 7'h20, 32'h0000_0011, 0, 32'hFFFF_FFFF, 1'b0, lat, acc, psel_n, stable, acc_ok);
    chk("blk_latency", lat, 3);
    chk("blk_cmd_ready_at_rsp", cmd_ready, 0);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 7'h21; cmd_wdata = 32'h0;
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cmd_ready !== 1'b0 || psel !== 1'b0 || rsp_valid !== 1'b1 ||
          rsp_rdata !== 32'h0 || rsp_err !== 1'b0) hold_ok = 1'b0;
    end
    chk("blk_stall_held", hold_ok, 1);
    rsp_ready = 1'b1;
    #1;
    chk("blk_ready_same_cycle", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("blk_setup_psel", psel, 1);
    chk("blk_setup_penable", penable, 0);
    chk("blk_setup_paddr", paddr, 7'h21);
    chk("blk_rsp_consumed", rsp_valid, 0);
    @(negedge clk);
    chk("blk_access_penable", penable, 1);
    pready = 1'b1; prdata = 32'h0000_0077;
    @(negedge clk);
    pready = 1'b0;
    chk("blk_rsp_valid", rsp_valid, 1);
    chk("blk_rsp_rdata", rsp_rdata, 32'h0000_0077);
    @(negedge clk);

`ifdef APB_MASTER_TIMEOUT_EN
    // PREADY stuck low: the transfer is aborted after 16 ACCESS cycles.
    run_xfer(1'b0, 7'h33, 32'h0, 1000, 32'h5555_5555, 1'b0, lat, acc, psel_n, stable, acc_ok);
    chk("to_latency", lat, 18);
    chk("to_access_cycles", acc, 16);
    chk("to_psel", psel, 0);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    chk("to_pulse", timeout, 1);
    @(negedge clk);
    chk("to_pulse_end", timeout, 0);
    chk("to_rsp_consumed", rsp_valid, 0);
    // Set up a stuck transfer for the reset test.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 7'h44; pready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
`else
    // PREADY stuck low without the timeout: still in ACCESS after 100 cycles.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 7'h33; pready = 1'b0;
    hold_ok = 1'b1;
    for (int i = 0; i < 102; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (rsp_valid !== 1'b0 || timeout !== 1'b0) hold_ok = 1'b0;
    end
    chk("nto_no_rsp", hold_ok, 1);
    chk("nto_psel", psel, 1);
    chk("nto_penable", penable, 1);
`endif

    // Reset for one cycle during ACCESS.
    chk("rst_pre_penable", penable, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_psel", psel, 0);
    chk("mid_rst_penable", penable, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_paddr", paddr, 0);
    pready = 1'b1; prdata = 32'h9999_9999;
    hold_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || psel !== 1'b0) hold_ok = 1'b0;
    end
    chk("mid_rst_no_rsp", hold_ok, 1);
    pready = 1'b0;

    // Normal service after reset.
    run_xfer(1'b0, 7'h05, 32'h0, 0, 32'hCAFE_F00D, 1'b0, lat, acc, psel_n, stable, acc_ok);
    chk("post_rst_latency", lat, 3);
    chk("post_rst_rdata", rsp_rdata, 32'hCAFE_F00D);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
